// File: rtl/thing_lifo.sv
`default_nettype none
// ============================================================================
// thing_lifo : things-path LIFO; stacks item bytes, pops thing_num per ';',
//              finishes on '$'. Optional macro THING_ZERO_MARK_EN emits a '0'
//              marker beat for groups that pop nothing.
// Revision   : 1.0
// ============================================================================
module thing_lifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ready_lifo,
   input  logic [DATA_W-1:0] thing_in,
   input  logic [3:0]        thing_num,
   output logic              busy,
   output logic              valid_lifo,
   output logic [DATA_W-1:0] thing_out,
   output logic              done_thing,
   output logic              done_lifo
);

   localparam int                c_CNT_W     = (ADDR_W + 1 > 4) ? ADDR_W + 1 : 4;
   localparam logic [ADDR_W:0]   c_SP_FULL   = (ADDR_W + 1)'(DEPTH);
   localparam logic [DATA_W-1:0] c_GRP_END   = DATA_W'(8'h3B);
   localparam logic [DATA_W-1:0] c_STR_END   = DATA_W'(8'h24);
   localparam logic [DATA_W-1:0] c_ZERO_MARK = DATA_W'(8'h30);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_FIN  = 2'd2,
      S_END  = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [ADDR_W:0]     r_sp, w_sp_nxt;
   logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic                r_mark, w_mark_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_valid, w_valid_nxt;
   logic [DATA_W-1:0]   r_out, w_out_nxt;
   logic                r_done_thing, w_done_thing_nxt;
   logic                r_done_lifo, w_done_lifo_nxt;

   logic                w_push;
   logic [ADDR_W-1:0]   w_wr_idx;
   logic [ADDR_W-1:0]   w_top_idx;
   logic [c_CNT_W-1:0]  w_num_ext;
   logic [c_CNT_W-1:0]  w_sp_ext;
   logic [c_CNT_W-1:0]  w_clamp;

   // Low ADDR_W bits of sp address the array; sp==DEPTH wraps to the right top index.
   assign w_wr_idx  = r_sp[ADDR_W-1:0];
   assign w_top_idx = r_sp[ADDR_W-1:0] - ADDR_W'(1);
   assign w_num_ext = c_CNT_W'(thing_num);
   assign w_sp_ext  = c_CNT_W'(r_sp);
   assign w_clamp   = (w_num_ext < w_sp_ext) ? w_num_ext : w_sp_ext;

   always_comb begin
      w_state_nxt      = r_state;
      w_sp_nxt         = r_sp;
      w_cnt_nxt        = r_cnt;
      w_mark_nxt       = r_mark;
      w_busy_nxt       = r_busy;
      w_valid_nxt      = 1'b0;
      w_out_nxt        = r_out;
      w_done_thing_nxt = 1'b0;
      w_done_lifo_nxt  = r_done_lifo;
      w_push           = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (ready_lifo) begin
               if (thing_in == c_GRP_END) begin
                  w_cnt_nxt  = w_clamp;
                  w_busy_nxt = 1'b1;
                  w_mark_nxt = 1'b0;
                  if (w_clamp == '0) begin
`ifdef THING_ZERO_MARK_EN
                     w_mark_nxt  = 1'b1;
                     w_state_nxt = S_POP;
`else
                     w_state_nxt = S_FIN;
`endif
                  end else begin
                     w_state_nxt = S_POP;
                  end
               end else if (thing_in == c_STR_END) begin
                  w_done_lifo_nxt = 1'b1;
                  w_state_nxt     = S_END;
               end else if (r_sp != c_SP_FULL) begin
                  w_push   = 1'b1;
                  w_sp_nxt = r_sp + (ADDR_W + 1)'(1);
               end
            end
         end

         S_POP: begin
            if (r_mark) begin
               w_out_nxt   = c_ZERO_MARK;
               w_valid_nxt = 1'b1;
               w_mark_nxt  = 1'b0;
               w_state_nxt = S_FIN;
            end else if (r_cnt != '0) begin
               w_out_nxt   = r_mem[w_top_idx];
               w_valid_nxt = 1'b1;
               w_sp_nxt    = r_sp - (ADDR_W + 1)'(1);
               w_cnt_nxt   = r_cnt - c_CNT_W'(1);
               if (r_cnt == c_CNT_W'(1)) begin
                  w_state_nxt = S_FIN;
               end
            end else begin
               w_state_nxt = S_FIN;
            end
         end

         S_FIN: begin
            w_done_thing_nxt = 1'b1;
            w_busy_nxt       = 1'b0;
            w_state_nxt      = S_IDLE;
         end

         S_END: begin
            w_done_lifo_nxt = 1'b1;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_sp         <= '0;
         r_cnt        <= '0;
         r_mark       <= 1'b0;
         r_busy       <= 1'b0;
         r_valid      <= 1'b0;
         r_out        <= '0;
         r_done_thing <= 1'b0;
         r_done_lifo  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sp         <= w_sp_nxt;
         r_cnt        <= w_cnt_nxt;
         r_mark       <= w_mark_nxt;
         r_busy       <= w_busy_nxt;
         r_valid      <= w_valid_nxt;
         r_out        <= w_out_nxt;
         r_done_thing <= w_done_thing_nxt;
         r_done_lifo  <= w_done_lifo_nxt;
      end
   end

   // Storage carries no reset; occupancy is defined solely by sp.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[w_wr_idx] <= thing_in;
      end
   end

   assign busy       = r_busy;
   assign valid_lifo = r_valid;
   assign thing_out  = r_out;
   assign done_thing = r_done_thing;
   assign done_lifo  = r_done_lifo;

endmodule
`default_nettype wire
